regfile_wr_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between two sources.
- Source one is pipeline writeback (high priority, no backpressure). Source two is an auxiliary producer, such as a multi-cycle unit or debug port, using a valid/ready handshake and buffered in a small FIFO.
- Drives the register file write port from registered outputs.
- Raises a one-cycle writeback stall so auxiliary writes cannot starve.

---
 rtl/regfile_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wr_arbiter: shares one register-file write port between pipeline  |
// | writeback and a FIFO-buffered aux producer. Optional: WR_ARB_BYPASS_EN.   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wb_valid,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         aux_valid,
    output logic                         aux_ready,
    input  logic [ADDR_W-1:0]            aux_addr,
    input  logic [DATA_W-1:0]            aux_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            write_addr,
    output logic [DATA_W-1:0]            write_data,
    output logic                         wb_stall,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         proto_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT+1);
    localparam int c_ENT_W = ADDR_W + DATA_W;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;
    logic               r_wb_stall;
    logic               r_aux_ready;
    logic               r_proto_err;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_write_addr;
    logic [DATA_W-1:0]  r_write_data;

    logic               w_push;
    logic               w_fifo_push;
    logic               w_pop;
    logic               w_waiting;
    logic               w_head_zero;
    logic               w_wb_live;
    logic               w_bypass;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_STV_W-1:0] w_starve_next;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;

    assign w_push      = aux_valid & r_aux_ready;
    assign w_waiting   = (r_count != '0);
    assign {w_head_addr, w_head_data} = r_mem[r_rd_ptr];
    assign w_head_zero = w_waiting & (w_head_addr == '0);
    // Writes to x0 are architecturally discarded, so they never claim the port.
    assign w_wb_live   = wb_valid & (wb_addr != '0);

`ifdef WR_ARB_BYPASS_EN
    assign w_bypass = w_push & ~w_waiting & ~w_wb_live & ~r_wb_stall;
`else
    assign w_bypass = 1'b0;
`endif

    // An x0 head drains even while writeback owns the port.
    assign w_pop       = w_waiting & (w_head_zero | ~w_wb_live);
    assign w_fifo_push = w_push & ~w_bypass;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_wb_live) begin
            w_wr_en   = 1'b1;
            w_wr_addr = wb_addr;
            w_wr_data = wb_data;
        end else if (w_waiting && !w_head_zero) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_head_addr;
            w_wr_data = w_head_data;
        end else if (w_bypass && (aux_addr != '0)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = aux_addr;
            w_wr_data = aux_data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_fifo_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_fifo_push && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_starve_next = r_starve;
        if (!w_waiting || w_pop) begin
            w_starve_next = '0;
        end else if (r_starve != c_STV_W'(STARVE_LIMIT)) begin
            w_starve_next = r_starve + c_STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_mem[r_wr_ptr] <= {aux_addr, aux_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_wb_stall   <= 1'b0;
            r_aux_ready  <= 1'b0;
            r_proto_err  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            if (w_fifo_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count      <= w_count_next;
            r_starve     <= w_starve_next;
            r_wb_stall   <= (w_starve_next == c_STV_W'(STARVE_LIMIT));
            // Ready follows the post-update occupancy; no pass-through when full.
            r_aux_ready  <= (w_count_next < c_CNT_W'(DEPTH));
            if (wb_valid && r_wb_stall) begin
                r_proto_err <= 1'b1;
            end
            r_wr_en      <= w_wr_en;
            r_write_addr <= w_wr_addr;
            r_write_data <= w_wr_data;
        end
    end

    assign aux_ready  = r_aux_ready;
    assign wr_en      = r_wr_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign wb_stall   = r_wb_stall;
    assign fifo_count = r_count;
    assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_wr_arbiter: vector table, directed corner sequences and random |
// | traffic against a queue-based reference model.  Revision: 1.0             |
// +----------------------------------------------------------------------------+
module tb_regfile_wr_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int CNT_W        = $clog2(DEPTH+1);
`ifdef WR_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_data;
    logic              wr_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              wb_stall;
    logic [CNT_W-1:0]  fifo_count;
    logic              proto_err;

    regfile_wr_arbiter #(
        .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
        .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
        .wb_stall(wb_stall), .fifo_count(fifo_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of pending aux writes plus the visible outputs.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;
    ent_t              q[$];
    int                m_starve;
    bit                m_stall, m_ready, m_perr, m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    typedef struct packed {
        logic              wbv;
        logic [ADDR_W-1:0] wba;
        logic [DATA_W-1:0] wbd;
        logic              auv;
        logic [ADDR_W-1:0] aua;
        logic [DATA_W-1:0] aud;
        logic              e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic [CNT_W-1:0]  e_cnt;
        logic              e_rdy;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_ready  = 1'b0;
        m_perr   = 1'b0;
        m_wr_en  = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic model_tick();
        bit push, wb_live, was_empty, pop, byp;
        push      = aux_valid && m_ready;
        wb_live   = wb_valid && (wb_addr != 0);
        was_empty = (q.size() == 0);
        pop       = 1'b0;
        byp       = BYP && push && was_empty && !wb_live && !m_stall;
        if (m_stall && wb_valid) m_perr = 1'b1;
        m_wr_en = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        if (wb_live) begin
            m_wr_en = 1'b1;
            m_addr  = wb_addr;
            m_data  = wb_data;
            if (!was_empty && q[0].a == 0) pop = 1'b1;
        end else if (!was_empty) begin
            pop = 1'b1;
            if (q[0].a != 0) begin
                m_wr_en = 1'b1;
                m_addr  = q[0].a;
                m_data  = q[0].d;
            end
        end else if (byp && aux_addr != 0) begin
            m_wr_en = 1'b1;
            m_addr  = aux_addr;
            m_data  = aux_data;
        end
        if (pop) void'(q.pop_front());
        if (push && !byp) q.push_back({aux_addr, aux_data});
        if (was_empty || pop) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        m_stall = (m_starve == STARVE_LIMIT);
        m_ready = (q.size() < DEPTH);
    endtask

    task automatic compare_model();
        chk("wr_en",      64'(wr_en),      64'(m_wr_en));
        chk("write_addr", 64'(write_addr), 64'(m_addr));
        chk("write_data", 64'(write_data), 64'(m_data));
        chk("wb_stall",   64'(wb_stall),   64'(m_stall));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("aux_ready",  64'(aux_ready),  64'(m_ready));
        chk("proto_err",  64'(proto_err),  64'(m_perr));
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        aux_valid = 1'b0;
        aux_addr  = '0;
        aux_data  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        reset_n = 1'b1;
    endtask

    // Pushes aux entries under continuous writeback, then runs until stall shows.
    task automatic fill_and_starve(input int n_push, input int base, output int n_wait);
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'h99;
        for (int k = 0; k < n_push; k++) begin
            aux_valid = 1'b1;
            aux_addr  = ADDR_W'(base + k);
            aux_data  = 32'h100 + 32'(k);
            step();
        end
        aux_valid = 1'b0;
        n_wait = 0;
        while (!wb_stall && n_wait < 20) begin
            step();
            n_wait++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;

        tbl[0] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
        tbl[1] = '{1'b1, 5'd5, 32'hAB,   1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hAB, 3'd0, 1'b1};
        tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
        tbl[3] = BYP ? '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b1, 5'd7, 32'h1234, 3'd0, 1'b1}
                     : '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0,    3'd1, 1'b1};
        tbl[4] = BYP ? '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    3'd0, 1'b1}
                     : '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 3'd0, 1'b1};
        tbl[5] = '{1'b1, 5'd0, 32'hFF,   1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  3'd0, 1'b1};
        tbl[6] = BYP ? '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1}
                     : '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 3'd1, 1'b1};
        tbl[7] = BYP ? '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h66, 3'd0, 1'b1}
                     : '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,  3'd1, 1'b1};
        tbl[8] = BYP ? '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  3'd0, 1'b1}
                     : '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 3'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            wb_valid  = tbl[i].wbv;
            wb_addr   = tbl[i].wba;
            wb_data   = tbl[i].wbd;
            aux_valid = tbl[i].auv;
            aux_addr  = tbl[i].aua;
            aux_data  = tbl[i].aud;
            step();
            chk($sformatf("tbl%0d_wr_en", i), 64'(wr_en),      64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_addr", i),  64'(write_addr), 64'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_data", i),  64'(write_data), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ready", i), 64'(aux_ready),  64'(tbl[i].e_rdy));
        end

        // Starvation with a well-behaved pipeline that drops wb_valid on stall.
        do_reset();
        idle_inputs();
        step();
        fill_and_starve(4, 1, nw);
        chk("s3_denied_cycles", 64'(nw), 64'd5);
        chk("s3_count_full", 64'(fifo_count), 64'(DEPTH));
        chk("s3_ready_low", 64'(aux_ready), 64'd0);
        wb_valid = 1'b0;
        step();
        chk("s3_head_write", 64'({wr_en, write_addr}), 64'({1'b1, 5'd1}));
        chk("s3_stall_one_cycle", 64'(wb_stall), 64'd0);
        chk("s3_no_proto_err", 64'(proto_err), 64'd0);
        repeat (4) step();

        // Same, but the pipeline ignores the stall.
        do_reset();
        idle_inputs();
        step();
        fill_and_starve(4, 1, nw);
        wb_data = 32'h77;
        step();
        chk("s4_wb_written", 64'({wr_en, write_addr, write_data}), 64'({1'b1, 5'd9, 32'h77}));
        chk("s4_proto_err", 64'(proto_err), 64'd1);
        chk("s4_stall_again", 64'(wb_stall), 64'd1);
        wb_valid = 1'b0;
        step();
        chk("s4_head_write", 64'({wr_en, write_addr}), 64'({1'b1, 5'd1}));
        chk("s4_proto_sticky", 64'(proto_err), 64'd1);
        repeat (4) step();

        // x0 from both sources in the same cycle.
        do_reset();
        idle_inputs();
        step();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
        aux_valid = 1'b1; aux_addr = 5'd0; aux_data = 32'hDEAD;
        step();
        wb_addr = 5'd0; wb_data = 32'hBEEF;
        aux_addr = 5'd6; aux_data = 32'h66;
        step();
        chk("s5_no_x0_write", 64'(wr_en), 64'd0);
        chk("s5_count", 64'(fifo_count), 64'd1);
        idle_inputs();
        step();
        chk("s5_addr6_write", 64'({wr_en, write_addr, write_data}), 64'({1'b1, 5'd6, 32'h66}));

        // Asynchronous reset with three buffered entries and stall raised.
        do_reset();
        idle_inputs();
        step();
        fill_and_starve(3, 11, nw);
        chk("s6_count3", 64'(fifo_count), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_count", 64'(fifo_count), 64'd0);
        chk("s6_rst_wr_en", 64'(wr_en), 64'd0);
        chk("s6_rst_stall", 64'(wb_stall), 64'd0);
        chk("s6_rst_ready", 64'(aux_ready), 64'd0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("s6_no_stale_write", 64'(wr_en), 64'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int rate;
            rate      = ((i / 250) % 2 == 1) ? 92 : 40;
            wb_valid  = ($urandom_range(0, 99) < rate);
            if (wb_stall && $urandom_range(0, 9) != 0) wb_valid = 1'b0;
            wb_addr   = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
            wb_data   = $urandom;
            aux_valid = ($urandom_range(0, 1) == 1);
            aux_addr  = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
            aux_data  = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
